bram_line_writer: RTL and testbench
===================================

Name: bram_line_writer

Overview:
Upstream fill stage for BRAM_inst. Accepts a valid/ready stream of IN_WIDTH-bit words and packs RATIO = DATA_WIDTH/IN_WIDTH words into one DATA_WIDTH line. Writes each line to consecutive BRAM addresses from 0 through its wr_en/write_addr/data_in port. Signals done when the buffer is full or the fill is flushed early, so a downstream reader can start on BRAM_inst.

Parameters:
DATA_WIDTH, 128, BRAM line width; must equal BRAM_inst DATA_WIDTH.
ADDR_WIDTH, 3, BRAM address width; buffer depth = 2**ADDR_WIDTH lines.
IN_WIDTH, 32, input word width; DATA_WIDTH must be an integer multiple of it (elaboration-time assertion).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a fill at address 0.
flush  input  1  one-cycle pulse; ends the fill early and writes any partial line.
in_valid  input  1  upstream word valid.
in_data  input  IN_WIDTH  upstream word.
in_ready  output  1  word accepted on the cycle where in_valid && in_ready.
wr_en  output  1  BRAM write strobe; connects to BRAM_inst wr_en.
write_addr  output  ADDR_WIDTH  BRAM write address.
data_in  output  DATA_WIDTH  BRAM write data; connects to BRAM_inst data_in.
busy  output  1  high while in FILL.
done  output  1  high while in DONE.
line_count  output  ADDR_WIDTH+1  number of lines written in the current or last fill.

Behaviour:
- Reset (async, while rst=1): state=IDLE. All outputs 0: in_ready, wr_en, write_addr, data_in, busy, done, line_count. Lane counter and assembly register cleared. Applies mid-fill too; any partial line is discarded.
- States: IDLE, FILL, DONE.
- IDLE: in_ready=0. start -> FILL; line_count, lane counter and write pointer cleared. flush is ignored.
- FILL: in_ready=1 combinationally from state. busy=1.
  - Each accepted word goes into lane lane_cnt, bits [lane_cnt*IN_WIDTH +: IN_WIDTH]. The first word of a line occupies the LSBs.
  - When lane RATIO-1 is accepted, the next cycle has wr_en=1 for exactly one cycle. write_addr=ptr and data_in=assembled line, all registered. ptr and line_count then increment; lane_cnt returns to 0.
  - Back-to-back acceptance continues with no bubble during the write cycle. Throughput is 1 word/cycle.
  - If the accepted word completes line 2**ADDR_WIDTH-1, the state goes to DONE on the same edge. The final write still occurs in the following cycle. in_ready is 0 from that cycle on.
- flush in FILL:
  - Any word accepted in the same cycle is captured first.
  - If lane_cnt (after capture) > 0: write the partial line next cycle with unfilled lanes zero, increment line_count, go to DONE.
  - If lane_cnt = 0: go to DONE with no write.
  - If the same-cycle word completed a line, that normal write is the only write.
- DONE: done=1, in_ready=0. start -> FILL (fresh fill from address 0). flush is ignored.
- start in FILL is ignored.
- wr_en is never asserted outside the cycle following a line completion or flush.
- line_count saturates naturally at 2**ADDR_WIDTH (hence ADDR_WIDTH+1 bits). write_addr never wraps within one fill.
- in_data is don't-care when in_valid=0. Gaps in in_valid simply stall the lane counter.

Decomposition:
- Shared package ot_bram_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, DONE} bram_wr_state_t.
  - Function lanes(DATA_WIDTH, IN_WIDTH) returning RATIO.
- No sub-module. Packing register, lane counter and FSM live in one module of roughly 150 lines.

Test Plan (DATA_WIDTH=128, ADDR_WIDTH=3, IN_WIDTH=32, DUT wired to BRAM_inst):
- Full fill: start, then 32 words value i with in_valid held high -> 8 wr_en pulses at addresses 0..7. ram[k] = {4k+3,4k+2,4k+1,4k}, e.g. ram[0] = 0x00000003_00000002_00000001_00000000. done=1, line_count=8, in_ready=0 after the last word.
- Early flush: start, 6 words (0..5), flush -> ram[0] = 0x3_2_1_0 and ram[1] = 0x00000000_00000000_00000005_00000004. line_count=2, done=1, no write to address 2.
- Flush on a line boundary: 4 words, then flush with in_valid=0 -> exactly one write, line_count=1. Variant: flush together with the 4th word -> still exactly one write.
- Gapped valid: in_valid toggles every other cycle for 8 words -> ram[0..1] identical to the gap-free case, and wr_en pulses exactly 2 times.
- Reset mid-fill: assert rst asynchronously after 10 words -> outputs 0 immediately and state IDLE. A new start plus 4 words writes address 0 with the new data.
- Control robustness: start during FILL has no effect (ptr unchanged). start in DONE restarts and overwrites ram[0]. flush in IDLE does nothing.

Source files
------------

// File: rtl/bram_line_writer_pkg.sv
// Shared types and helpers for the BRAM line writer and its BRAM consumer.
package ot_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } bram_wr_state_t;

    // Number of input words packed into one BRAM line.
    function automatic int lanes(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

endpackage

// File: rtl/bram_line_writer.sv
// Packs a valid/ready stream of IN_WIDTH words into DATA_WIDTH lines and
// writes them to consecutive BRAM addresses starting at 0. Reports done when
// the buffer is full or the fill is flushed early.
module bram_line_writer
    import ot_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 3,
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   line_count
);

    localparam int RATIO  = lanes(DATA_WIDTH, IN_WIDTH);
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    generate
        if ((DATA_WIDTH % IN_WIDTH) != 0 || RATIO < 1) begin : g_width_check
            $error("bram_line_writer: DATA_WIDTH must be an integer multiple of IN_WIDTH");
        end
    endgenerate

    bram_wr_state_t          state;
    logic [LANE_W-1:0]       lane_cnt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   asm_line;
    logic [DATA_WIDTH-1:0]   line_next;
    logic                    accept;
    logic                    line_done;
    logic                    partial;

    // Status and handshake decode straight from the state register.
    assign in_ready = (state == FILL);
    assign busy     = (state == FILL);
    assign done     = (state == DONE);

    assign accept    = in_valid && in_ready;
    assign line_done = accept && (lane_cnt == LAST_LANE);
    // A flush has something to write if any lane holds data after capture.
    assign partial   = accept || (lane_cnt != '0);

    // Merge the word being accepted into its lane of the line under assembly.
    always_comb begin
        line_next = asm_line;
        if (accept) begin
            line_next[int'(lane_cnt)*IN_WIDTH +: IN_WIDTH] = in_data;
        end
    end

    // Fill FSM: lane packing, line write strobe, address pointer and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            ptr        <= '0;
            asm_line   <= '0;
            wr_en      <= 1'b0;
            write_addr <= '0;
            data_in    <= '0;
            line_count <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= FILL;
                        lane_cnt   <= '0;
                        ptr        <= '0;
                        asm_line   <= '0;
                        line_count <= '0;
                    end
                end

                FILL: begin
                    if (line_done) begin
                        // Full line: write it next cycle, start a clean line.
                        wr_en      <= 1'b1;
                        write_addr <= ptr;
                        data_in    <= line_next;
                        ptr        <= ptr + ADDR_WIDTH'(1);
                        line_count <= line_count + CNT_W'(1);
                        lane_cnt   <= '0;
                        asm_line   <= '0;
                        if (flush || ptr == LAST_ADDR) begin
                            state <= DONE;
                        end
                    end else if (flush) begin
                        // Early end: unfilled lanes are already zero.
                        if (partial) begin
                            wr_en      <= 1'b1;
                            write_addr <= ptr;
                            data_in    <= line_next;
                            ptr        <= ptr + ADDR_WIDTH'(1);
                            line_count <= line_count + CNT_W'(1);
                        end
                        lane_cnt <= '0;
                        asm_line <= '0;
                        state    <= DONE;
                    end else if (accept) begin
                        asm_line <= line_next;
                        lane_cnt <= lane_cnt + LANE_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_line_writer.sv
// Scoreboard bench for bram_line_writer with a behavioural BRAM on its write port.
module tb_bram_line_writer;

    localparam int DW = 128;
    localparam int AW = 3;
    localparam int IW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;
    logic [AW:0]   line_count;

    bram_line_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .write_addr(write_addr), .data_in(data_in),
        .busy(busy), .done(done), .line_count(line_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    logic [DW-1:0]    ram [DEPTH];
    logic [AW+DW-1:0] exp_q [$];

    // Bench model of the packer.
    logic [DW-1:0] m_line;
    int            m_lane;
    int            m_ptr;
    bit            m_fill;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // BRAM model plus write-port scoreboard.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            ram[write_addr] = data_in;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {write_addr, data_in}, '0);
            end else begin
                check("wr_line", {write_addr, data_in}, exp_q.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    task automatic model_accept(input logic [IW-1:0] v);
        m_line[m_lane*IW +: IW] = v;
        m_lane++;
        if (m_lane == DW/IW) begin
            exp_q.push_back({AW'(m_ptr), m_line});
            m_ptr++;
            m_lane = 0;
            m_line = '0;
            if (m_ptr == DEPTH) m_fill = 0;
        end
    endtask

    task automatic model_flush();
        if (m_lane > 0) begin
            exp_q.push_back({AW'(m_ptr), m_line});
            m_ptr++;
        end
        m_lane = 0;
        m_line = '0;
        m_fill = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!m_fill) begin
            m_fill = 1; m_lane = 0; m_ptr = 0; m_line = '0;
        end
    endtask

    task automatic send(input logic [IW-1:0] v, input bit with_flush);
        in_valid = 1'b1;
        in_data  = v;
        flush    = with_flush;
        @(posedge clk);
        if (m_fill) model_accept(v);
        if (with_flush && m_fill) model_flush();
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        if (m_fill) model_flush();
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, done, 1'b1);
        idle(2);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int w0;
        m_fill = 0; m_lane = 0; m_ptr = 0; m_line = '0;

        // Reset state.
        idle(3);
        check("rst_outputs", {in_ready, wr_en, write_addr, data_in, busy, done, line_count}, '0);
        rst = 1'b0;
        idle(1);

        // flush in IDLE does nothing.
        do_flush();
        idle(2);
        check("idle_flush", {wr_cnt, busy, done, in_ready}, '0);

        // Full fill of all eight lines.
        do_start();
        check("fill_busy", {busy, in_ready, done}, 3'b110);
        for (int i = 0; i < 4*DEPTH; i++) send(IW'(i), 0);
        check("full_ready_low", {in_ready, done}, 2'b01);
        wait_done("full_done");
        check("full_writes", wr_cnt, DEPTH);
        check("full_count", line_count, DEPTH);
        check("full_ram0", ram[0], mk(0, 1, 2, 3));
        check("full_ram7", ram[7], mk(28, 29, 30, 31));

        // Early flush after six words.
        w0 = wr_cnt;
        do_start();
        for (int i = 0; i < 6; i++) send(IW'(i), 0);
        do_flush();
        wait_done("eflush_done");
        check("eflush_writes", wr_cnt - w0, 2);
        check("eflush_count", line_count, 2);
        check("eflush_ram0", ram[0], mk(0, 1, 2, 3));
        check("eflush_ram1", ram[1], 128'h00000000_00000000_00000005_00000004);
        check("eflush_ram2", ram[2], mk(8, 9, 10, 11));

        // Flush on a line boundary with in_valid low.
        w0 = wr_cnt;
        do_start();
        for (int i = 0; i < 4; i++) send(IW'(32'h10 + i), 0);
        do_flush();
        wait_done("bflush_done");
        check("bflush_writes", wr_cnt - w0, 1);
        check("bflush_count", line_count, 1);

        // Flush together with the fourth word.
        w0 = wr_cnt;
        do_start();
        for (int i = 0; i < 3; i++) send(IW'(32'h20 + i), 0);
        send(32'h23, 1);
        wait_done("wflush_done");
        check("wflush_writes", wr_cnt - w0, 1);
        check("wflush_count", line_count, 1);
        check("wflush_ram0", ram[0], mk(32'h20, 32'h21, 32'h22, 32'h23));

        // Gapped valid.
        w0 = wr_cnt;
        do_start();
        for (int i = 0; i < 8; i++) begin
            send(IW'(i), 0);
            idle(1);
        end
        do_flush();
        wait_done("gap_done");
        check("gap_writes", wr_cnt - w0, 2);
        check("gap_ram0", ram[0], mk(0, 1, 2, 3));
        check("gap_ram1", ram[1], mk(4, 5, 6, 7));

        // Asynchronous reset mid-fill.
        do_start();
        for (int i = 0; i < 10; i++) send(IW'(32'h40 + i), 0);
        #2 rst = 1'b1;
        #1;
        check("amid_rst", {in_ready, wr_en, write_addr, data_in, busy, done, line_count}, '0);
        m_fill = 0; m_lane = 0; m_ptr = 0; m_line = '0;
        check("amid_sb", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = wr_cnt;
        do_start();
        for (int i = 0; i < 4; i++) send(IW'(32'h60 + i), 0);
        do_flush();
        wait_done("rst_refill_done");
        check("rst_refill_writes", wr_cnt - w0, 1);
        check("rst_refill_ram0", ram[0], mk(32'h60, 32'h61, 32'h62, 32'h63));

        // start during FILL is ignored; start in DONE restarts at address 0.
        w0 = wr_cnt;
        do_start();
        send(32'h70, 0);
        send(32'h71, 0);
        do_start();
        send(32'h72, 0);
        send(32'h73, 0);
        send(32'h74, 0);
        do_flush();
        wait_done("fstart_done");
        check("fstart_writes", wr_cnt - w0, 2);
        check("fstart_ram0", ram[0], mk(32'h70, 32'h71, 32'h72, 32'h73));
        check("fstart_ram1", ram[1], mk(32'h74, 0, 0, 0));
        check("fstart_count", line_count, 2);

        do_start();
        check("restart_busy", {busy, done}, 2'b10);
        for (int i = 0; i < 4; i++) send(IW'(32'h80 + i), 0);
        do_flush();
        wait_done("restart_done");
        check("restart_ram0", ram[0], mk(32'h80, 32'h81, 32'h82, 32'h83));
        check("restart_count", line_count, 1);

        // flush in DONE is ignored.
        w0 = wr_cnt;
        do_flush();
        idle(2);
        check("done_flush", {wr_cnt - w0, done, line_count}, {32'd0, 1'b1, 4'd1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
